// File: rtl/rgb_pkg.sv
// rgb_pkg: state encoding and colour constants shared by the RGB light logic.
// Revision: 1.0
`default_nettype none

package rgb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RED   = 3'd1,
        ST_GREEN = 3'd2,
        ST_BLUE  = 3'd3,
        ST_FORCE = 3'd4
    } state_t;

    localparam logic [2:0] COLOR_OFF   = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;

endpackage

`default_nettype wire

// File: rtl/rgb_light_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter that stalls on hold and saturates at zero.
// Revision: 1.0
`default_nettype none

module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rgb_light_ctrl.sv
// rgb_light_ctrl: sequences the RGB light red->green->blue with per-colour dwell,
// hold, enable and a priority override. Revision: 1.0
`default_nettype none

module rgb_light_ctrl
    import rgb_pkg::*;
#(
    parameter int          CNT_W      = 8,
    parameter int unsigned RED_TIME   = 3,
    parameter int unsigned GREEN_TIME = 2,
    parameter int unsigned BLUE_TIME  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    input  logic             force_req,
    input  logic [2:0]       force_color,
    output logic             force_ack,
    output logic [2:0]       light,
    output logic             step,
    output logic [CNT_W-1:0] cycle_cnt
);

    // The counter holds "cycles remaining minus one", so a TIME of 0 collapses to 1.
    localparam logic [CNT_W-1:0] RED_LOAD   = (RED_TIME   == 0) ? '0 : CNT_W'(RED_TIME   - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD = (GREEN_TIME == 0) ? '0 : CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] BLUE_LOAD  = (BLUE_TIME  == 0) ? '0 : CNT_W'(BLUE_TIME  - 1);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             cyc_inc;
    logic             dwell_zero;
    logic [2:0]       next_light;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .hold     (hold),
        .zero     (dwell_zero)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = RED_LOAD;
        cyc_inc    = 1'b0;
        if (force_req) begin
            next_state = ST_FORCE;
        end else begin
            case (state)
                ST_IDLE, ST_FORCE: begin
                    if (en) begin
                        next_state = ST_RED;
                        load       = 1'b1;
                        load_val   = RED_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
                ST_RED, ST_GREEN, ST_BLUE: begin
                    if (!en) begin
                        next_state = ST_IDLE;
                    end else if (!hold && dwell_zero) begin
                        load = 1'b1;
                        case (state)
                            ST_RED: begin
                                next_state = ST_GREEN;
                                load_val   = GREEN_LOAD;
                            end
                            ST_GREEN: begin
                                next_state = ST_BLUE;
                                load_val   = BLUE_LOAD;
                            end
                            default: begin
                                next_state = ST_RED;
                                load_val   = RED_LOAD;
                                cyc_inc    = 1'b1;
                            end
                        endcase
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        next_light = COLOR_OFF;
        case (next_state)
            ST_RED:   next_light = COLOR_RED;
            ST_GREEN: next_light = COLOR_GREEN;
            ST_BLUE:  next_light = COLOR_BLUE;
            ST_FORCE: next_light = force_color;
            default:  next_light = COLOR_OFF;
        endcase
    end

    // A reload happens exactly when a fresh colour phase begins, so it doubles as step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            light     <= COLOR_OFF;
            force_ack <= 1'b0;
            step      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= next_state;
            light     <= next_light;
            force_ack <= (next_state == ST_FORCE);
            step      <= load;
            if (cyc_inc) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgb_light_ctrl.sv
// tb_rgb_light_ctrl: directed bench with a phase/remaining-time model of the light
// sequence, checked every cycle for a default instance and a RED_TIME=0 instance.
`default_nettype none

module tb_rgb_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       force_req = 1'b0;
    logic [2:0] force_color = 3'b000;
    logic       cmp_en = 1'b0;

    logic       ack0, ack1, step0, step1;
    logic [2:0] light0, light1;
    logic [7:0] cyc0, cyc1;

    int errors = 0;
    int checks = 0;

    rgb_light_ctrl dut0 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .force_req(force_req),
        .force_color(force_color), .force_ack(ack0), .light(light0), .step(step0),
        .cycle_cnt(cyc0)
    );

    rgb_light_ctrl #(.RED_TIME(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .force_req(force_req),
        .force_color(force_color), .force_ack(ack1), .light(light1), .step(step1),
        .cycle_cnt(cyc1)
    );

    always #5 clk = ~clk;

    // Model: mode 0=off, 1=cycling colours, 2=overridden; left = visible cycles remaining.
    int         m_mode[2];
    int         m_col[2];
    int         m_left[2];
    logic [7:0] m_cyc[2];
    logic [2:0] m_light[2];
    logic       m_step[2];
    logic       m_ack[2];

    function automatic int dur(input int inst, input int col);
        int t;
        case (col)
            0:       t = (inst == 0) ? 3 : 0;
            1:       t = 2;
            default: t = 4;
        endcase
        return (t == 0) ? 1 : t;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_col[i] = 0; m_left[i] = 0; m_cyc[i] = 8'd0;
                m_step[i] = 1'b0; m_ack[i] = 1'b0;
            end else if (force_req) begin
                m_mode[i] = 2; m_step[i] = 1'b0; m_ack[i] = 1'b1;
                m_light[i] = force_color;
            end else if (m_mode[i] != 1) begin
                m_ack[i] = 1'b0;
                if (en) begin
                    m_mode[i] = 1; m_col[i] = 0; m_left[i] = dur(i, 0); m_step[i] = 1'b1;
                end else begin
                    m_mode[i] = 0; m_step[i] = 1'b0;
                end
            end else if (!en) begin
                m_mode[i] = 0; m_step[i] = 1'b0;
            end else if (hold) begin
                m_step[i] = 1'b0;
            end else if (m_left[i] > 1) begin
                m_left[i] = m_left[i] - 1; m_step[i] = 1'b0;
            end else begin
                if (m_col[i] == 2) m_cyc[i] = m_cyc[i] + 8'd1;
                m_col[i] = (m_col[i] + 1) % 3;
                m_left[i] = dur(i, m_col[i]);
                m_step[i] = 1'b1;
            end
            if (m_mode[i] == 0) m_light[i] = 3'b000;
            else if (m_mode[i] == 1) m_light[i] = 3'b100 >> m_col[i];
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0_light", 32'(light0), 32'(m_light[0]));
            chk("m0_step",  32'(step0),  32'(m_step[0]));
            chk("m0_ack",   32'(ack0),   32'(m_ack[0]));
            chk("m0_cyc",   32'(cyc0),   32'(m_cyc[0]));
            chk("m1_light", 32'(light1), 32'(m_light[1]));
            chk("m1_step",  32'(step1),  32'(m_step[1]));
            chk("m1_ack",   32'(ack1),   32'(m_ack[1]));
            chk("m1_cyc",   32'(cyc1),   32'(m_cyc[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_light0(input logic [2:0] col);
        for (int n = 0; n < 50; n++) begin
            if (light0 === col) break;
            tick();
        end
        chk("wait_colour", 32'(light0), 32'(col));
    endtask

    logic [2:0] fr_light[9] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010,
                                3'b001, 3'b001, 3'b001, 3'b001};
    logic       fr_step[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int cnt;
        repeat (2) tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();
        chk("reset_light", 32'(light0), 32'h0);
        chk("reset_cyc", 32'(cyc0), 32'h0);
        chk("reset_ack", 32'(ack0), 32'h0);

        // Free run from edge 0
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("free_light", 32'(light0), 32'(fr_light[k]));
            chk("free_step", 32'(step0), 32'(fr_step[k]));
            if (k == 0) chk("r0_red", 32'(light1), 32'h4);
            if (k == 1) chk("r0_green", 32'(light1), 32'h2);
        end
        tick();
        chk("edge9_light", 32'(light0), 32'h4);
        chk("edge9_step", 32'(step0), 32'h1);
        chk("edge9_cyc", 32'(cyc0), 32'h1);

        // Hold during green
        repeat (3) tick();
        chk("green_start", 32'(light0), 32'h2);
        cnt = 1;
        hold = 1'b1;
        repeat (5) begin
            tick();
            if (light0 === 3'b010) cnt++;
        end
        hold = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (light0 === 3'b010) cnt++;
            else break;
        end
        chk("hold_green_len", 32'(cnt), 32'd7);
        chk("hold_then_blue", 32'(light0), 32'h1);
        chk("hold_cyc", 32'(cyc0), 32'h1);

        // Override mid-blue
        tick();
        force_req = 1'b1;
        force_color = 3'b111;
        tick();
        chk("force_light", 32'(light0), 32'h7);
        chk("force_ack", 32'(ack0), 32'h1);
        force_color = 3'b101;
        tick();
        chk("force_track", 32'(light0), 32'h5);
        force_req = 1'b0;
        tick();
        chk("release_red", 32'(light0), 32'h4);
        chk("release_ack", 32'(ack0), 32'h0);
        chk("release_step", 32'(step0), 32'h1);
        repeat (2) tick();
        chk("release_red3", 32'(light0), 32'h4);
        tick();
        chk("release_green", 32'(light0), 32'h2);
        chk("force_cyc", 32'(cyc0), 32'h1);

        // Disable mid-red
        wait_light0(3'b100);
        tick();
        en = 1'b0;
        tick();
        chk("disable_off", 32'(light0), 32'h0);
        en = 1'b1;
        tick();
        chk("reenable_red", 32'(light0), 32'h4);
        repeat (2) tick();
        chk("reenable_red3", 32'(light0), 32'h4);
        tick();
        chk("reenable_green", 32'(light0), 32'h2);

        // Asynchronous reset during blue
        wait_light0(3'b001);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_light", 32'(light0), 32'h0);
        chk("async_cyc", 32'(cyc0), 32'h0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_reset_idle", 32'(light0), 32'h0);

        // Override on the final blue cycle: no cycle count
        en = 1'b1;
        tick();
        repeat (8) tick();
        chk("last_blue", 32'(light0), 32'h1);
        force_req = 1'b1;
        force_color = 3'b011;
        tick();
        chk("expiry_force_ack", 32'(ack0), 32'h1);
        chk("expiry_force_cyc", 32'(cyc0), 32'h0);
        force_req = 1'b0;
        tick();
        repeat (2) tick();
        // Hold on the final red cycle defers the transition
        hold = 1'b1;
        tick();
        chk("hold_expiry_red", 32'(light0), 32'h4);
        chk("hold_expiry_step", 32'(step0), 32'h0);
        hold = 1'b0;
        tick();
        chk("hold_expiry_green", 32'(light0), 32'h2);

        // Mixed stimulus, checked by the model
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 4) == 0);
            force_req = ($urandom_range(0, 9) == 0);
            force_color = 3'($urandom_range(0, 7));
            tick();
        end

        // Wrap of cycle_cnt
        en = 1'b0; hold = 1'b0; force_req = 1'b0;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b1;
        tick();
        repeat (9 * 255) tick();
        chk("wrap_255", 32'(cyc0), 32'd255);
        repeat (9) tick();
        chk("wrap_0", 32'(cyc0), 32'd0);
        chk("wrap_red", 32'(light0), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
